// File: rtl/ex_div_pkg.sv
// Shared types and constants for the EX-stage iterative divider.
package ex_div_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int RES_W  = 2 * DATA_W;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    DIV_FREE,
    DIV_BYZERO,
    DIV_ON,
    DIV_END
  } div_state_t;

  function automatic logic [DATA_W-1:0] neg(
    input logic [DATA_W-1:0] v
  );
    return ~v + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] mag(
    input logic              sgn,
    input logic [DATA_W-1:0] v
  );
    return (sgn && v[DATA_W-1]) ? neg(v) : v;
  endfunction

endpackage

// File: rtl/ex_div_if.sv
// EX <-> divider request/result bundle.
// EX is master; the divider is slave.
interface ex_div_if;
  import ex_div_pkg::*;

  logic              signed_div;
  logic [DATA_W-1:0] opdata1;
  logic [DATA_W-1:0] opdata2;
  logic              start;
  logic              annul;
  logic [RES_W-1:0]  result;
  logic              ready;

  modport master (
    output signed_div, opdata1, opdata2,
    output start, annul,
    input  result, ready
  );

  modport slave (
    input  signed_div, opdata1, opdata2,
    input  start, annul,
    output result, ready
  );

endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider for DIV/DIVU.
// One quotient bit per cycle; {rem, quo} out.
module ex_div
  import ex_div_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  io
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DATA_W);

  div_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [RES_W:0]    work, work_n;
  logic [DATA_W-1:0] dvsr, dvsr_n;
  logic              neg_a, neg_a_n;
  logic              neg_b, neg_b_n;
  logic [RES_W-1:0]  result, result_n;
  logic              ready, ready_n;

  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] quo, rem;

  assign trial =
    {1'b0, work[RES_W-1:DATA_W]} - {1'b0, dvsr};
  assign quo = work[DATA_W-1:0];
  assign rem = work[RES_W:DATA_W+1];

  assign io.result = result;
  assign io.ready  = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DIV_FREE;
      cnt    <= '0;
      work   <= '0;
      dvsr   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      work   <= work_n;
      dvsr   <= dvsr_n;
      neg_a  <= neg_a_n;
      neg_b  <= neg_b_n;
      result <= result_n;
      ready  <= ready_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    work_n   = work;
    dvsr_n   = dvsr;
    neg_a_n  = neg_a;
    neg_b_n  = neg_b;
    result_n = result;
    ready_n  = ready;

    unique case (state)
      DIV_FREE: begin
        ready_n  = 1'b0;
        result_n = '0;
        if (io.start && !io.annul) begin
          if (io.opdata2 == ZERO_WORD) begin
            state_n = DIV_BYZERO;
          end else begin
            state_n = DIV_ON;
            cnt_n   = '0;
            neg_a_n = io.signed_div &
                      io.opdata1[DATA_W-1];
            neg_b_n = io.signed_div &
                      io.opdata2[DATA_W-1];
            dvsr_n  = mag(io.signed_div,
                          io.opdata2);
            work_n  = {ZERO_WORD,
                       mag(io.signed_div,
                           io.opdata1),
                       1'b0};
          end
        end
      end

      DIV_BYZERO: begin
        state_n  = DIV_END;
        result_n = '0;
        ready_n  = 1'b1;
      end

      DIV_ON: begin
        if (io.annul) begin
          state_n  = DIV_FREE;
          ready_n  = 1'b0;
          result_n = '0;
          cnt_n    = '0;
          work_n   = '0;
        end else if (cnt != LAST) begin
          // Borrow out of the trial means "does not fit"
          if (trial[DATA_W]) begin
            work_n = {work[RES_W-1:0], 1'b0};
          end else begin
            work_n = {trial[DATA_W-1:0],
                      work[DATA_W-1:0], 1'b1};
          end
          cnt_n = cnt + 1'b1;
        end else begin
          state_n  = DIV_END;
          ready_n  = 1'b1;
          result_n = {neg_a ? neg(rem) : rem,
                      (neg_a ^ neg_b) ? neg(quo)
                                      : quo};
        end
      end

      DIV_END: begin
        ready_n = 1'b1;
        if (!io.start) begin
          state_n  = DIV_FREE;
          ready_n  = 1'b0;
          result_n = '0;
        end
      end

      default: begin
        state_n = DIV_FREE;
      end
    endcase
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: latency, signs,
// div-by-zero, annul, reset and handshake.
module tb_ex_div;
  import ex_div_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_div_if bus ();

  ex_div dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch and wait for ready; start stays high.
  task automatic run(
    input  logic        sd,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat,
    output int          stall
  );
    bus.signed_div = sd;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.start      = 1'b1;
    lat   = 0;
    stall = 0;
    while (!bus.ready && lat < 100) begin
      if (bus.start && !bus.ready) stall++;
      tick();
      lat++;
    end
  endtask

  task automatic drop();
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %0b want 0",
               bus.ready);
    end
    checks++;
    if (bus.result !== 64'd0) begin
      errors++;
      $display("FAIL reset_result got %h want 0",
               bus.result);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_divu_basic();
    int lat, st;
    run(1'b0, 32'd100, 32'd7, lat, st);
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL divu_lat got %0d want 34", lat);
    end
    checks++;
    if (st !== 34) begin
      errors++;
      $display("FAIL divu_stall got %0d want 34", st);
    end
    checks++;
    if (bus.result !== 64'h00000002_0000000E) begin
      errors++;
      $display("FAIL divu_100_7 got %h want %h",
               bus.result, 64'h00000002_0000000E);
    end
    drop();
    checks++;
    if (bus.ready !== 1'b0 ||
        bus.result !== 64'd0) begin
      errors++;
      $display("FAIL divu_drop got %0b/%h want 0/0",
               bus.ready, bus.result);
    end
  endtask

  task automatic test_signed();
    int lat;
    bus.signed_div = 1'b1;
    bus.opdata1    = 32'hFFFF_FFF9;
    bus.opdata2    = 32'd2;
    bus.start      = 1'b1;
    tick();
    // operands change after the start edge
    bus.opdata1    = 32'd55;
    bus.opdata2    = 32'd0;
    bus.signed_div = 1'b0;
    lat = 1;
    while (!bus.ready && lat < 100) begin
      tick();
      lat++;
    end
    checks++;
    if (bus.result !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++;
      $display("FAIL div_m7_2 got %h want %h",
               bus.result, 64'hFFFFFFFF_FFFFFFFD);
    end
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL div_m7_lat got %0d want 34", lat);
    end
    drop();
  endtask

  task automatic test_overflow();
    int lat, st;
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
        lat, st);
    checks++;
    if (bus.result !== 64'h00000000_80000000) begin
      errors++;
      $display("FAIL div_ovf got %h want %h",
               bus.result, 64'h00000000_80000000);
    end
    drop();
    run(1'b0, 32'hFFFF_FFFF, 32'd1, lat, st);
    checks++;
    if (bus.result !== 64'h00000000_FFFFFFFF) begin
      errors++;
      $display("FAIL divu_max_1 got %h want %h",
               bus.result, 64'h00000000_FFFFFFFF);
    end
    drop();
  endtask

  task automatic test_div_zero();
    int lat, st;
    for (int s = 0; s < 2; s++) begin
      run(s[0], 32'd77, 32'd0, lat, st);
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL dz_lat s=%0d got %0d want 2",
                 s, lat);
      end
      checks++;
      if (bus.result !== 64'd0) begin
        errors++;
        $display("FAIL dz_res s=%0d got %h want 0",
                 s, bus.result);
      end
      drop();
      checks++;
      if (bus.ready !== 1'b0) begin
        errors++;
        $display("FAIL dz_drop s=%0d got %0b want 0",
                 s, bus.ready);
      end
    end
  endtask

  task automatic test_annul();
    int lat, st, seen;
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd1000;
    bus.opdata2    = 32'd3;
    bus.start      = 1'b1;
    seen = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (bus.ready) seen++;
    end
    bus.annul = 1'b1;
    tick();
    checks++;
    if (dut.state !== DIV_FREE) begin
      errors++;
      $display("FAIL annul_state got %0d want %0d",
               dut.state, DIV_FREE);
    end
    // start held with annul: nothing launches
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ready) seen++;
    end
    checks++;
    if (seen !== 0 || dut.state !== DIV_FREE) begin
      errors++;
      $display("FAIL annul_ready got %0d/%0d want 0/%0d",
               seen, dut.state, DIV_FREE);
    end
    bus.annul = 1'b0;
    drop();
    run(1'b0, 32'd9, 32'd3, lat, st);
    checks++;
    if (bus.result !== 64'h00000000_00000003 ||
        lat !== 34) begin
      errors++;
      $display("FAIL annul_next got %h/%0d want %h/34",
               bus.result, lat, 64'd3);
    end
    // annul is ignored once in END
    bus.annul = 1'b1;
    tick();
    checks++;
    if (bus.ready !== 1'b1 ||
        bus.result !== 64'd3) begin
      errors++;
      $display("FAIL annul_end got %0b/%h want 1/%h",
               bus.ready, bus.result, 64'd3);
    end
    bus.annul = 1'b0;
    drop();
  endtask

  task automatic test_reset_mid();
    int lat, st;
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd1000;
    bus.opdata2    = 32'd3;
    bus.start      = 1'b1;
    for (int i = 0; i < 21; i++) tick();
    rst = 1'b1;
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.ready !== 1'b0 ||
        dut.state !== DIV_FREE) begin
      errors++;
      $display("FAIL rst_on got %0b/%0d want 0/%0d",
               bus.ready, dut.state, DIV_FREE);
    end
    rst = 1'b0;
    tick();
    run(1'b0, 32'd1000, 32'd3, lat, st);
    checks++;
    if (bus.result !== 64'h00000001_0000014D) begin
      errors++;
      $display("FAIL divu_1000_3 got %h want %h",
               bus.result, 64'h00000001_0000014D);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.ready !== 1'b0 ||
        bus.result !== 64'd0) begin
      errors++;
      $display("FAIL rst_end got %0b/%h want 0/0",
               bus.ready, bus.result);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    run(1'b1, 32'd100, 32'hFFFF_FFF9, lat, st);
    checks++;
    if (bus.result !== 64'h00000002_FFFFFFF2 ||
        lat !== 34) begin
      errors++;
      $display("FAIL rst_after got %h/%0d want %h/34",
               bus.result, lat, 64'h00000002_FFFFFFF2);
    end
    drop();
  endtask

  task automatic test_back_to_back();
    int lat, st, bad;
    run(1'b0, 32'd50, 32'd6, lat, st);
    // start stays high: result must hold in END
    bus.opdata1 = 32'd7;
    bus.opdata2 = 32'd7;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.ready !== 1'b1 ||
          bus.result !== 64'h00000002_00000008)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_hold got %0d bad want 0",
               bad);
    end
    drop();
    run(1'b0, 32'd7, 32'd7, lat, st);
    checks++;
    if (bus.result !== 64'h00000000_00000001 ||
        lat !== 34) begin
      errors++;
      $display("FAIL b2b_next got %h/%0d want %h/34",
               bus.result, lat, 64'd1);
    end
    drop();
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.start      = 1'b0;
    bus.annul      = 1'b0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_overflow();
    test_div_zero();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative 32-bit integer divider instantiated inside the EX stage.
- Consumes the source operands and ALU op that EX receives from the ID/EX pipeline register.
- Serves DIV and DIVU, producing a 64-bit {remainder, quotient} result for HI/LO writeback.
- Multi-cycle: EX holds its stall request high while the divider is busy. This freezes PC, IF/ID and ID/EX until the result is ready.

Parameters:
- DATA_W, 32, operand width; result width is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled only on the start edge.
- opdata1  input  32  dividend; sampled only on the start edge.
- opdata2  input  32  divisor; sampled only on the start edge.
- start  input  1  EX holds this high for the whole operation and drops it after seeing ready.
- annul  input  1  pipeline flush; aborts the current operation.
- result  output  64  {remainder[63:32], quotient[31:0]}; valid while ready=1.
- ready  output  1  result valid.

Behaviour:
- Reset: state=FREE, result=0, ready=0, internal counter and dividend register cleared. Reset applies in any state and aborts an operation in progress.
- States: FREE, BYZERO, ON, END.
- FREE:
  - If start=1, annul=0 and opdata2==0: go to BYZERO.
  - If start=1, annul=0 and opdata2!=0: go to ON, counter=0.
    - Latch absolute values when signed_div=1 (two's-complement negate if bit31=1); otherwise latch raw values.
    - Latch the sign of each operand.
    - Working register = {32'b0, |dividend|, 1'b0}.
  - Otherwise: stay in FREE with ready=0 and result=0.
- BYZERO: unconditionally go to END with result=0. Divide-by-zero raises no exception.
- ON:
  - If annul=1: go to FREE, ready=0, result=0, working state discarded.
  - Else, if counter<32: perform one restoring step.
    - Trial = upper bits minus divisor.
    - If trial is negative: shift left, quotient bit=0.
    - Else: replace upper bits with trial, shift left, quotient bit=1.
    - Increment counter.
  - Else (counter==32): finalize and go to END, ready=1.
    - If signed_div=1 and the operand signs differ: negate the quotient.
    - If signed_div=1 and the dividend was negative: negate the remainder.
    - The remainder sign always follows the dividend.
- END:
  - ready=1 and result held stable.
  - When start=0: go to FREE, ready=0, result=0.
  - annul has no effect in END.
- Latency, counting from the edge that samples start in FREE:
  - Normal divide: ready=1 after edge 34 (1 setup edge, 32 iteration edges, 1 finalize edge).
  - Divide-by-zero: ready=1 after edge 2.
- Start held high in FREE while annul=1: remain in FREE; no operation launches.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient wraps to 0x80000000, remainder=0. No trap.
- Operands changing after the start edge do not affect the operation in flight.
- Back-to-back divides: a new operation cannot launch until start has been low for at least one edge (END→FREE).
- EX stall request = start & ~ready. EX drives start=1 for DIV/DIVU while ready=0 and annul=0, and drives start=0 once it has consumed ready.

Decomposition:
- defines.v gains the following:
  - State encodings: DivFree, DivByZero, DivOn, DivEnd.
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
  - DoubleRegBus (63:0).
  - ALU op codes for DIV and DIVU.
- Reuses the existing RstEnable, ZeroWord, Stop and NotStop constants.
- No sub-module. The absolute-value/negate helper is an internal function.
- EX instantiates ex_div and ORs its busy signal into the stall request to ctrl.

Test Plan:
- DIVU 100 / 7 → ready after 34 edges; result = {0x00000002, 0x0000000E}; stall request high for exactly 34 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Divisor 0 (signed or unsigned) → ready after 2 edges, result=0; after start drops, ready=0 on the next edge.
- Start DIVU 1000/3, then assert annul at iteration 10 → ready never asserted, state FREE on the next edge; a fresh DIVU 9/3 then returns {0, 3}.
- Assert rst at iteration 20, then in END → result=0 and ready=0 on the following edge; a subsequent divide completes normally.
